// File: rtl/gpio_irq_pkg.sv
// Shared constants for the GPIO interrupt Wishbone slave: register map,
// data width and the default debounce length.
package gpio_irq_pkg;
    localparam int DATA_W           = 8;
    localparam int DEBOUNCE_DEFAULT = 16;

    localparam logic [1:0] ADR_PENDING  = 2'd0;
    localparam logic [1:0] ADR_ENABLE   = 2'd1;
    localparam logic [1:0] ADR_POLARITY = 2'd2;
    localparam logic [1:0] ADR_LEVEL    = 2'd3;
endpackage

// File: rtl/gpio_debounce_bit.sv
// Single-pin debouncer: the stable level follows the synchronised input only
// after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module gpio_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sync_i,
    output logic db_o
);
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync_i != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) db_d = sync_i;
            else                                     cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign db_o = db_q;
endmodule

// File: rtl/gpio_irq_wb8.sv
// 8-bit Wishbone GPIO interrupt controller: sync, optional debounce
// (GPIO_IRQ_DEBOUNCE_EN), per-pin edge polarity, W1C pending, masked level IRQ.
module gpio_irq_wb8
    import gpio_irq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 16
) (
    input  logic              I_wb_clk,
    input  logic              I_reset_n,
    input  logic [1:0]        I_wb_adr,
    input  logic [DATA_W-1:0] I_wb_dat,
    input  logic              I_wb_stb,
    input  logic              I_wb_we,
    output logic              O_wb_ack,
    output logic [DATA_W-1:0] O_wb_dat,
    input  logic [DATA_W-1:0] I_gpio_in,
    output logic              O_irq
);
    logic [DATA_W-1:0] sync1_q, sync2_q, prev_q;
    logic [DATA_W-1:0] pending_q, pending_d, enable_q, polarity_q;
    logic [DATA_W-1:0] rdat_q, rmux, cond, evt, w1c;
    logic              ack_q, irq_q, wr, rd;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 || DEBOUNCE_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
        $error("gpio_irq_wb8: DEBOUNCE_CYCLES must be 1..65535 and below 2**CNT_W");
    end

`ifdef GPIO_IRQ_DEBOUNCE_EN
    for (genvar i = 0; i < DATA_W; i++) begin : g_db
        gpio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk_i (I_wb_clk),
            .rst_ni(I_reset_n),
            .sync_i(sync2_q[i]),
            .db_o  (cond[i])
        );
    end
`else
    assign cond = sync2_q;
`endif

    assign wr  = I_wb_stb & I_wb_we;
    assign rd  = I_wb_stb & ~I_wb_we;
    assign evt = (polarity_q & cond & ~prev_q) | (~polarity_q & ~cond & prev_q);
    assign w1c = (wr && I_wb_adr == ADR_PENDING) ? I_wb_dat : '0;

    // Set has priority over a same-cycle clear so no event is lost.
    assign pending_d = (pending_q & ~w1c) | (evt & enable_q);

    always_comb begin
        rmux = '0;
        case (I_wb_adr)
            ADR_PENDING:  rmux = pending_q;
            ADR_ENABLE:   rmux = enable_q;
            ADR_POLARITY: rmux = polarity_q;
            ADR_LEVEL:    rmux = cond;
            default:      rmux = '0;
        endcase
    end

    always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            pending_q  <= '0;
            enable_q   <= '0;
            polarity_q <= '0;
            rdat_q     <= '0;
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q   <= I_gpio_in;
            sync2_q   <= sync1_q;
            prev_q    <= cond;
            pending_q <= pending_d;
            ack_q     <= I_wb_stb;
            irq_q     <= |(pending_q & enable_q);
            if (wr && I_wb_adr == ADR_ENABLE)   enable_q   <= I_wb_dat;
            if (wr && I_wb_adr == ADR_POLARITY) polarity_q <= I_wb_dat;
            if (rd) rdat_q <= rmux;
        end
    end

    assign O_wb_ack = ack_q;
    assign O_wb_dat = rdat_q;
    assign O_irq    = irq_q;
endmodule

// File: tb/tb_gpio_irq_wb8.sv
// Directed self-checking bench for gpio_irq_wb8 (both default and debounce builds).
module tb_gpio_irq_wb8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] adr = '0;
    logic [7:0] wdat = '0;
    logic       stb = 1'b0;
    logic       we = 1'b0;
    logic       ack;
    logic [7:0] rdat;
    logic [7:0] gpio = '0;
    logic       irq;
    logic [7:0] rv;
    int         n_cmp = 0;
    int         n_err = 0;

`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int EXTRA = 4;
`else
    localparam int EXTRA = 0;
`endif

    gpio_irq_wb8 #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
        .I_wb_clk (clk),
        .I_reset_n(rst_n),
        .I_wb_adr (adr),
        .I_wb_dat (wdat),
        .I_wb_stb (stb),
        .I_wb_we  (we),
        .O_wb_ack (ack),
        .O_wb_dat (rdat),
        .I_gpio_in(gpio),
        .O_irq    (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %02h want %02h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns just after a negedge with bus idle.
    task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
        adr = a; wdat = d; stb = 1'b1; we = 1'b1;
        @(negedge clk);
        chk("wr_ack", {7'd0, ack}, 8'h01);
        stb = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [7:0] d);
        chk("rd_ack_pre", {7'd0, ack}, 8'h00);
        adr = a; stb = 1'b1; we = 1'b0;
        @(negedge clk);
        chk("rd_ack", {7'd0, ack}, 8'h01);
        d = rdat;
        stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        // 1: reset state and register reads
        #1;
        chk("rst_ack", {7'd0, ack}, 8'h00);
        chk("rst_irq", {7'd0, irq}, 8'h00);
        chk("rst_dat", rdat, 8'h00);
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 4; a++) begin
            wb_read(2'(a), rv);
            chk("rst_reg", rv, 8'h00);
        end
        chk("rst_irq2", {7'd0, irq}, 8'h00);

        // 2: rising edge on pin0, exact IRQ latency, W1C
        wb_write(2'd1, 8'h01);
        wb_write(2'd2, 8'h01);
        gpio = 8'h01;
        for (int k = 0; k < 3 + EXTRA; k++) begin
            @(negedge clk);
            chk("t2_irq_early", {7'd0, irq}, 8'h00);
        end
        @(negedge clk);
        chk("t2_irq_rise", {7'd0, irq}, 8'h01);
        wb_read(2'd0, rv);
        chk("t2_pend", rv, 8'h01);
        wb_write(2'd0, 8'h01);
        chk("t2_irq_clr", {7'd0, irq}, 8'h00);
        wb_read(2'd0, rv);
        chk("t2_pend_clr", rv, 8'h00);

        // 3: falling polarity on pin7, disabled pin3 ignored
        wb_write(2'd2, 8'h00);
        wb_write(2'd1, 8'h80);
        gpio = 8'h81; idle(10);
        wb_read(2'd0, rv);
        chk("t3_rise_ign", rv, 8'h00);
        gpio = 8'h01; idle(10);
        wb_read(2'd0, rv);
        chk("t3_fall", rv, 8'h80);
        chk("t3_irq", {7'd0, irq}, 8'h01);
        gpio = 8'h81; idle(10);
        wb_read(2'd0, rv);
        chk("t3_rise2", rv, 8'h80);
        gpio = 8'h89; idle(10);
        gpio = 8'h81; idle(10);
        wb_read(2'd0, rv);
        chk("t3_pin3", rv, 8'h80);
        wb_write(2'd0, 8'hFF);
        wb_read(2'd0, rv);
        chk("t3_clr", rv, 8'h00);

        // 4: W1C collides with a set on pin2; masking keeps the pending bit
        wb_write(2'd2, 8'h04);
        wb_write(2'd1, 8'h04);
        gpio = 8'h85;
        idle(2 + EXTRA);
        wb_write(2'd0, 8'h04);
        wb_read(2'd0, rv);
        chk("t4_collide", rv, 8'h04);
        chk("t4_irq", {7'd0, irq}, 8'h01);
        wb_write(2'd1, 8'h00);
        chk("t4_irq_mask", {7'd0, irq}, 8'h00);
        wb_read(2'd0, rv);
        chk("t4_pend_kept", rv, 8'h04);
        wb_read(2'd3, rv);
        chk("t4_level", rv, 8'h85);
        wb_write(2'd3, 8'h00);
        wb_read(2'd3, rv);
        chk("t4_level_ro", rv, 8'h85);
        wb_write(2'd0, 8'hFF);

`ifdef GPIO_IRQ_DEBOUNCE_EN
        // 5: debounce rejects a 3-cycle glitch, accepts a 6-cycle pulse
        wb_write(2'd2, 8'h02);
        wb_write(2'd1, 8'h02);
        gpio = 8'h87; idle(3);
        gpio = 8'h85; idle(12);
        wb_read(2'd0, rv);
        chk("t5_glitch", rv, 8'h00);
        wb_read(2'd3, rv);
        chk("t5_lvl_low", rv & 8'h02, 8'h00);
        gpio = 8'h87; idle(6);
        idle(6);
        wb_read(2'd0, rv);
        chk("t5_pend", rv, 8'h02);
        wb_read(2'd3, rv);
        chk("t5_lvl_high", rv & 8'h02, 8'h02);
`endif

        // 6: asynchronous reset in the middle of a read
        wb_write(2'd2, 8'hFF);
        wb_write(2'd1, 8'hFF);
        gpio = 8'h00; idle(12);
        wb_write(2'd0, 8'hFF);
        gpio = 8'hFF; idle(12);
        wb_read(2'd1, rv);
        chk("t6_en", rv, 8'hFF);
        chk("t6_irq", {7'd0, irq}, 8'h01);
        adr = 2'd0; stb = 1'b1; we = 1'b0;
        @(posedge clk); #2;
        chk("t6_ack_hi", {7'd0, ack}, 8'h01);
        chk("t6_dat", rdat, 8'hFF);
        rst_n = 1'b0;
        #1;
        chk("t6_ack_rst", {7'd0, ack}, 8'h00);
        chk("t6_irq_rst", {7'd0, irq}, 8'h00);
        chk("t6_dat_rst", rdat, 8'h00);
        stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        for (int a = 0; a < 3; a++) begin
            wb_read(2'(a), rv);
            chk("t6_reg_rst", rv, 8'h00);
        end
        idle(12);
        chk("t6_irq_after", {7'd0, irq}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
